// File: rtl/rc_settle_monitor.sv
// Step-response monitor: on every change of i_v_in, times how long i_v_out takes
// to sit inside +/-TOL of the new level for HOLD samples; flags timeout and overshoot.
//   state     | meaning
//   S_IDLE    | after reset or timeout, waiting for a step
//   S_TRACK   | step seen, counting cycles until settled or timed out
//   S_SETTLED | settle time reported, waiting for the next step
module rc_settle_monitor #(
  parameter int WIDTH   = 8,
  parameter int TOL     = 2,
  parameter int HOLD    = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_v_in,
  input  logic [WIDTH-1:0] i_v_out,
  output logic             o_busy,
  output logic             o_settle_valid,
  output logic [CNT_W-1:0] o_settle_time,
  output logic             o_timeout,
  output logic             o_overshoot
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_SETTLED = 2'd2
  } state_t;

  localparam logic [WIDTH:0]   L_TOL     = (WIDTH+1)'(TOL);
  localparam logic [CNT_W-1:0] L_HOLD    = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_ZERO    = '0;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_v_in_q;
  logic [WIDTH-1:0] r_target, w_target_nxt;
  logic             r_dir, w_dir_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_run, w_run_nxt;
  logic [CNT_W-1:0] r_first_in, w_first_in_nxt;
  logic [CNT_W-1:0] r_settle_time, w_settle_time_nxt;
  logic             r_settle_valid, w_settle_valid_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             r_overshoot, w_overshoot_nxt;

  logic             w_step;
  logic [WIDTH:0]   w_v_out_x, w_target_x, w_err;
  logic             w_in_band, w_over_hi, w_over_lo;
  logic [CNT_W-1:0] w_run_inc;
  logic             w_hold_hit;

  // One extra bit keeps target+TOL and v_out+TOL from wrapping near full scale.
  assign w_step     = (i_v_in != r_v_in_q);
  assign w_v_out_x  = {1'b0, i_v_out};
  assign w_target_x = {1'b0, r_target};
  assign w_err      = (w_v_out_x >= w_target_x) ? (w_v_out_x - w_target_x)
                                                : (w_target_x - w_v_out_x);
  assign w_in_band  = (w_err <= L_TOL);
  assign w_over_hi  = (w_v_out_x > (w_target_x + L_TOL));
  assign w_over_lo  = ((w_v_out_x + L_TOL) < w_target_x);
  assign w_run_inc  = r_run + L_ONE;
  assign w_hold_hit = w_in_band && (w_run_inc == L_HOLD);

  always_comb begin
    w_state_nxt        = r_state;
    w_target_nxt       = r_target;
    w_dir_nxt          = r_dir;
    w_cnt_nxt          = r_cnt;
    w_run_nxt          = r_run;
    w_first_in_nxt     = r_first_in;
    w_settle_time_nxt  = r_settle_time;
    w_settle_valid_nxt = 1'b0;
    w_timeout_nxt      = 1'b0;
    w_overshoot_nxt    = r_overshoot;

    if (w_step) begin
      w_target_nxt    = i_v_in;
      w_dir_nxt       = (i_v_in > r_v_in_q);
      w_cnt_nxt       = L_ONE;
      w_run_nxt       = L_ZERO;
      w_overshoot_nxt = 1'b0;
      w_state_nxt     = S_TRACK;
    end else begin
      unique case (r_state)
        S_TRACK: begin
          w_overshoot_nxt = r_overshoot | (r_dir ? w_over_hi : w_over_lo);
          if (w_in_band) begin
            w_run_nxt = w_run_inc;
            if (r_run == L_ZERO) w_first_in_nxt = r_cnt;
          end else begin
            w_run_nxt = L_ZERO;
          end

          if (w_hold_hit) begin
            w_settle_time_nxt  = (r_run == L_ZERO) ? r_cnt : r_first_in;
            w_settle_valid_nxt = 1'b1;
            w_state_nxt        = S_SETTLED;
          end else if (r_cnt == L_TIMEOUT) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + L_ONE;
          end
        end
        S_IDLE, S_SETTLED: begin
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_v_in_q       <= '0;
      r_target       <= '0;
      r_dir          <= 1'b0;
      r_cnt          <= '0;
      r_run          <= '0;
      r_first_in     <= '0;
      r_settle_time  <= '0;
      r_settle_valid <= 1'b0;
      r_timeout      <= 1'b0;
      r_overshoot    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_v_in_q       <= i_v_in;
      r_target       <= w_target_nxt;
      r_dir          <= w_dir_nxt;
      r_cnt          <= w_cnt_nxt;
      r_run          <= w_run_nxt;
      r_first_in     <= w_first_in_nxt;
      r_settle_time  <= w_settle_time_nxt;
      r_settle_valid <= w_settle_valid_nxt;
      r_timeout      <= w_timeout_nxt;
      r_overshoot    <= w_overshoot_nxt;
    end
  end

  assign o_busy         = (r_state == S_TRACK);
  assign o_settle_valid = r_settle_valid;
  assign o_settle_time  = r_settle_time;
  assign o_timeout      = r_timeout;
  assign o_overshoot    = r_overshoot;

endmodule

// File: tb/tb_rc_settle_monitor.sv
// Bench for rc_settle_monitor: directed steps with hand-computed settle results,
// checked by a pulse monitor against a queue of expected reports.
module tb_rc_settle_monitor;

  logic       clk;
  logic       rst_n;
  logic [7:0] v_in;
  logic [7:0] v_out;
  logic       busy;
  logic       settle_valid;
  logic [7:0] settle_time;
  logic       timeout;
  logic       overshoot;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int e;

  typedef struct {
    int kind;
    int stime;
    int ovs;
    int edge_n;
  } exp_t;
  exp_t exp_q[$];

  rc_settle_monitor #(
    .WIDTH(8), .TOL(2), .HOLD(4), .CNT_W(8), .TIMEOUT(200)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_v_in         (v_in),
    .i_v_out        (v_out),
    .o_busy         (busy),
    .o_settle_valid (settle_valid),
    .o_settle_time  (settle_time),
    .o_timeout      (timeout),
    .o_overshoot    (overshoot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind 0 = settle report, kind 1 = timeout; edge_n is the clock edge the pulse follows.
  task automatic push(input int kind, input int stime, input int ovs, input int edge_n);
    exp_t x;
    x.kind = kind;
    x.stime = stime;
    x.ovs = ovs;
    x.edge_n = edge_n;
    exp_q.push_back(x);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (settle_valid || timeout) begin
      if (settle_valid && timeout) check("dual_pulse", 1, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("pulse_kind", timeout ? 1 : 0, x.kind);
        check("settle_time", int'(settle_time), x.stime);
        check("overshoot", int'(overshoot), x.ovs);
        check("pulse_edge", cyc, x.edge_n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  int vals3[9]  = '{50, 40, 30, 27, 30, 32, 32, 32, 32};
  int vals6[14] = '{0, 0, 0, 0, 0, 0, 64, 64, 0, 64, 64, 64, 64, 64};
  int vals7[6]  = '{135, 128, 128, 128, 128, 128};

  initial begin
    rst_n = 1'b0;
    v_in  = 8'd0;
    v_out = 8'd0;
    ticks(3);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_settle_valid", int'(settle_valid), 0);
    check("rst_settle_time", int'(settle_time), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_overshoot", int'(overshoot), 0);
    ticks(1);
    rst_n = 1'b1;

    // quiet after reset: any pulse here is unexpected
    ticks(50);
    check("quiet_busy", int'(busy), 0);
    check("quiet_settle_time", int'(settle_time), 0);

    // 0 -> 64, v_out jumps to 64 from edge E+5
    v_in = 8'd64;
    e = cyc + 1;
    push(0, 5, 0, e + 8);
    ticks(1);
    check("step_busy", int'(busy), 1);
    ticks(4);
    v_out = 8'd64;
    ticks(10);
    check("settled_busy", int'(busy), 0);

    // 64 -> 32, downward ramp undershoots to 27 then recovers
    v_in = 8'd32;
    e = cyc + 1;
    push(0, 5, 1, e + 8);
    for (int i = 0; i < 9; i++) begin
      ticks(1);
      v_out = 8'(vals3[i]);
    end
    ticks(5);
    check("ovs_sticky", int'(overshoot), 1);

    // 32 -> 0 with v_out already there: minimum settle time of 1
    v_in = 8'd0;
    v_out = 8'd0;
    e = cyc + 1;
    push(0, 1, 0, e + 4);
    ticks(8);
    check("min_busy", int'(busy), 0);

    // 0 -> 64 with v_out stuck low: timeout
    v_in = 8'd64;
    e = cyc + 1;
    push(1, 1, 0, e + 200);
    ticks(200);
    check("pre_timeout_busy", int'(busy), 1);
    ticks(1);
    check("post_timeout_busy", int'(busy), 0);
    ticks(3);

    // step to 100, aborted by a step to 0 three edges later
    v_in = 8'd100;
    ticks(3);
    v_in = 8'd0;
    e = cyc + 1;
    push(0, 1, 0, e + 4);
    ticks(1);
    check("abort_busy", int'(busy), 1);
    ticks(8);

    // 0 -> 64, in-band run broken on its third sample
    v_in = 8'd64;
    e = cyc + 1;
    push(0, 10, 0, e + 13);
    for (int i = 0; i < 14; i++) begin
      ticks(1);
      v_out = 8'(vals6[i]);
    end
    ticks(4);

    // 64 -> 128, upward overshoot to 135 on the first sample
    v_in = 8'd128;
    e = cyc + 1;
    push(0, 2, 1, e + 5);
    for (int i = 0; i < 6; i++) begin
      ticks(1);
      v_out = 8'(vals7[i]);
    end
    ticks(4);

    // reset in the middle of tracking
    v_in = 8'd200;
    v_out = 8'd255;
    ticks(5);
    check("mid_busy", int'(busy), 1);
    check("mid_overshoot", int'(overshoot), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_overshoot", int'(overshoot), 0);
    check("mid_rst_settle_time", int'(settle_time), 0);
    v_in = 8'd0;
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    check("post_rst_busy", int'(busy), 0);

    check("pending_reports", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
